// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// mux4_rr_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares one 4:1, 1-bit selector among four
// requesters. Requester k's data sits on selector input ik. The arbiter drives
// the select lines {s1,s0} and returns a one-hot grant to the winner.
//
// The owner keeps its grant for as long as it keeps requesting. The optional
// hold limit forces a rotation once the owner has held the grant for MAX_HOLD
// consecutive cycles while another requester is waiting.
//
// Optional feature macro: MUX4_ARB_HOLD_LIMIT_EN
//   defined   : hold-limit enforcement with a saturating HOLD_W-bit counter
//   undefined : no forced rotation, and no hold counter is built
//
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles while another requester waits
//              (1..255; only meaningful with the hold limit built in)
//   HOLD_W   : width of the hold counter; 2**HOLD_W must exceed MAX_HOLD
//
// Ports:
//   clk   : system clock; all state changes on the rising edge
//   rst_n : asynchronous, active-low reset
//   req   : level-sensitive requests; bit k belongs to requester k
//   gnt   : registered one-hot grant; all-zero when idle
//   s0    : registered selector select bit 0
//   s1    : registered selector select bit 1
//   busy  : registered; high exactly while a grant is active
// ============================================================================
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_LIMIT_ON = 1'b1;
`else
    localparam bit HOLD_LIMIT_ON = 1'b0;
`endif

    localparam bit HOLD_CFG_OK = (MAX_HOLD >= 32'd1) && (MAX_HOLD <= 32'd255) &&
                                 ((HOLD_W >= 32'd31) || (MAX_HOLD < (32'd1 << HOLD_W)));

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [3:0] others;
    logic [1:0] winner;
    logic       grant_new;
    logic       grant_keep;
    logic       limit_hit;

    // One-hot encode a requester index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    // First set request bit found scanning upward from start, wrapping at 3.
    // The result is only used when at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign limit_hit = (hold_q == HOLD_MAX);

    // The counter restarts at 1 on every fresh grant, saturates while the
    // grant is kept, and clears when the arbiter falls idle.
    always_comb begin
        hold_d = hold_q;
        if (grant_new) begin
            hold_d = HOLD_ONE;
        end else if (grant_keep) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_ONE;
            end
        end else if (state_d == IDLE) begin
            hold_d = '0;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    // The owner is always last_q while in GRANT, so a single search from
    // last_q+1 serves both the IDLE pickup and every hand-over from GRANT.
    assign others = req & ~onehot(last_q);
    assign winner = rr_pick(req, last_q + 2'd1);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        grant_new  = 1'b0;
        grant_keep = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                if (req[last_q]) begin
                    if ((others != 4'b0000) && limit_hit) begin
                        grant_new = 1'b1;
                    end else begin
                        grant_keep = 1'b1;
                    end
                end else if (others != 4'b0000) begin
                    grant_new = 1'b1;
                end else begin
                    // The select lines keep the old owner so the selector
                    // output does not glitch on the way into idle.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase

        if (grant_new) begin
            state_d = GRANT;
            gnt_d   = onehot(winner);
            sel_d   = winner;
            busy_d  = 1'b1;
            last_d  = winner;
        end
    end

    // Last-owner pointer resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = busy_q;

`ifndef SYNTHESIS
    // Structural invariants of the registered outputs.
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));

    busy_matches_gnt_a: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (gnt_q != 4'b0000));

    sel_matches_gnt_a: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q |-> (gnt_q == onehot(sel_q)));

    sel_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (busy_q && $past(busy_q) && (gnt_q == $past(gnt_q))) |-> (sel_q == $past(sel_q)));

    hold_cfg_a: assert property (@(posedge clk) disable iff (!rst_n)
        HOLD_LIMIT_ON |-> HOLD_CFG_OK);
`endif

endmodule
